// File: rtl/fu_agu_sb.sv
// Load/store address-generation unit with an in-order store buffer.
// Loads forward from, wait behind, or bypass buffered stores; stores drain when memory is idle.
module fu_agu_sb #(
  parameter int unsigned SB_DEPTH = 4,
  parameter int unsigned TAG_W    = 6
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [7:0]       op,
  input  logic [31:0]      base,
  input  logic [31:0]      offset,
  input  logic [31:0]      st_data,
  input  logic [TAG_W-1:0] tag,
  output logic             res_valid,
  output logic [TAG_W-1:0] res_tag,
  output logic [31:0]      res_data,
  output logic             res_exc,
  output logic [31:0]      res_badvaddr,
  output logic             mem_req,
  output logic             mem_we,
  output logic [3:0]       mem_wen,
  output logic [31:0]      mem_addr,
  output logic [31:0]      mem_wdata,
  input  logic             mem_gnt,
  input  logic             mem_rvalid,
  input  logic [31:0]      mem_rdata,
  output logic             sb_empty
);

  localparam int unsigned PtrW = $clog2(SB_DEPTH);
  localparam int unsigned CntW = PtrW + 1;

  typedef enum logic [1:0] {StIdle, StHaz, StReq, StWait} state_e;

  state_e state_q, state_d;

  logic [29:0]     sb_addr_q [SB_DEPTH];
  logic [3:0]      sb_mask_q [SB_DEPTH];
  logic [31:0]     sb_data_q [SB_DEPTH];
  logic [PtrW-1:0] head_q, tail_q;
  logic [CntW-1:0] count_q;

  logic [31:0]      ld_addr_q;
  logic [3:0]       ld_mask_q;
  logic [7:0]       ld_op_q;
  logic [TAG_W-1:0] ld_tag_q;

  logic             res_valid_d, res_exc_d;
  logic [TAG_W-1:0] res_tag_d;
  logic [31:0]      res_data_d, res_badvaddr_d;

  logic [31:0] vaddr, st_repl;
  logic [3:0]  acc_mask, q_mask, hit_mask;
  logic [29:0] q_word;
  logic [31:0] hit_data;
  logic [PtrW-1:0] scan_idx;
  logic is_byte, is_half, is_word, is_load, is_store, misalign, accept;
  logic hit, push, pop, ld_capture;

  function automatic logic [31:0] load_fmt(input logic [31:0] w, input logic [1:0] lo,
                                           input logic [7:0] o);
    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] r;
    b = 8'(w >> {lo, 3'b000});
    h = lo[1] ? w[31:16] : w[15:0];
    r = w;
    if (o[7])      r = {{24{b[7]}}, b};
    else if (o[6]) r = {24'b0, b};
    else if (o[5]) r = {{16{h[15]}}, h};
    else if (o[4]) r = {16'b0, h};
    return r;
  endfunction

  assign vaddr    = base + offset;
  assign is_byte  = op[7] | op[6] | op[2];
  assign is_half  = op[5] | op[4] | op[1];
  assign is_word  = op[3] | op[0];
  assign is_load  = |op[7:3];
  assign is_store = |op[2:0];
  assign misalign = (is_half & vaddr[0]) | (is_word & (vaddr[1:0] != 2'b00));
  assign accept   = in_valid & in_ready;
  assign sb_empty = (count_q == '0);
  assign in_ready = !reset && (state_q == StIdle) && (count_q != CntW'(SB_DEPTH));

  always_comb begin
    acc_mask = 4'b0000;
    st_repl  = st_data;
    if (is_byte) begin
      acc_mask = 4'b0001 << vaddr[1:0];
      st_repl  = {4{st_data[7:0]}};
    end else if (is_half) begin
      acc_mask = vaddr[1] ? 4'b1100 : 4'b0011;
      st_repl  = {2{st_data[15:0]}};
    end else if (is_word) begin
      acc_mask = 4'b1111;
    end
  end

  // Scan oldest to youngest so the last match is the youngest overlapping store.
  always_comb begin
    q_word   = (state_q == StHaz) ? ld_addr_q[31:2] : vaddr[31:2];
    q_mask   = (state_q == StHaz) ? ld_mask_q : acc_mask;
    hit      = 1'b0;
    hit_mask = 4'b0000;
    hit_data = 32'h0;
    scan_idx = '0;
    for (int i = 0; i < SB_DEPTH; i++) begin
      scan_idx = head_q + PtrW'(i);
      if ((CntW'(i) < count_q) && (sb_addr_q[scan_idx] == q_word) &&
          ((sb_mask_q[scan_idx] & q_mask) != 4'b0000)) begin
        hit      = 1'b1;
        hit_mask = sb_mask_q[scan_idx];
        hit_data = sb_data_q[scan_idx];
      end
    end
  end

  always_comb begin
    state_d        = state_q;
    push           = 1'b0;
    pop            = 1'b0;
    ld_capture     = 1'b0;
    res_valid_d    = 1'b0;
    res_exc_d      = 1'b0;
    res_tag_d      = '0;
    res_data_d     = 32'h0;
    res_badvaddr_d = 32'h0;
    mem_req        = 1'b0;
    mem_we         = 1'b0;
    mem_wen        = 4'b0000;
    mem_addr       = 32'h0;
    mem_wdata      = 32'h0;

    if ((state_q != StReq) && (state_q != StWait) && (count_q != '0)) begin
      mem_req   = 1'b1;
      mem_we    = 1'b1;
      mem_wen   = sb_mask_q[head_q];
      mem_addr  = {sb_addr_q[head_q], 2'b00};
      mem_wdata = sb_data_q[head_q];
      pop       = mem_gnt;
    end

    case (state_q)
      StIdle: begin
        if (accept) begin
          if (misalign) begin
            res_valid_d    = 1'b1;
            res_exc_d      = 1'b1;
            res_badvaddr_d = vaddr;
            res_tag_d      = tag;
          end else if (is_store) begin
            push = 1'b1;
          end else if (is_load) begin
            ld_capture = 1'b1;
            if (!hit) begin
              state_d = StReq;
            end else if ((hit_mask & acc_mask) == acc_mask) begin
              res_valid_d = 1'b1;
              res_tag_d   = tag;
              res_data_d  = load_fmt(hit_data, vaddr[1:0], op);
            end else begin
              state_d = StHaz;
            end
          end
        end
      end
      StHaz: begin
        if (!hit) state_d = StReq;
      end
      StReq: begin
        mem_req  = 1'b1;
        mem_addr = {ld_addr_q[31:2], 2'b00};
        if (mem_gnt) state_d = StWait;
      end
      StWait: begin
        if (mem_rvalid) begin
          res_valid_d = 1'b1;
          res_tag_d   = ld_tag_q;
          res_data_d  = load_fmt(mem_rdata, ld_addr_q[1:0], ld_op_q);
          state_d     = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= StIdle;
      head_q       <= '0;
      tail_q       <= '0;
      count_q      <= '0;
      ld_addr_q    <= 32'h0;
      ld_mask_q    <= 4'b0000;
      ld_op_q      <= 8'h00;
      ld_tag_q     <= '0;
      res_valid    <= 1'b0;
      res_exc      <= 1'b0;
      res_tag      <= '0;
      res_data     <= 32'h0;
      res_badvaddr <= 32'h0;
      for (int i = 0; i < SB_DEPTH; i++) begin
        sb_addr_q[i] <= 30'h0;
        sb_mask_q[i] <= 4'b0000;
        sb_data_q[i] <= 32'h0;
      end
    end else begin
      state_q      <= state_d;
      res_valid    <= res_valid_d;
      res_exc      <= res_exc_d;
      res_tag      <= res_tag_d;
      res_data     <= res_data_d;
      res_badvaddr <= res_badvaddr_d;
      if (ld_capture) begin
        ld_addr_q <= vaddr;
        ld_mask_q <= acc_mask;
        ld_op_q   <= op;
        ld_tag_q  <= tag;
      end
      if (push) begin
        sb_addr_q[tail_q] <= vaddr[31:2];
        sb_mask_q[tail_q] <= acc_mask;
        sb_data_q[tail_q] <= st_repl;
        tail_q            <= tail_q + 1'b1;
      end
      if (pop) head_q <= head_q + 1'b1;
      if (push && !pop)      count_q <= count_q + 1'b1;
      else if (pop && !push) count_q <= count_q - 1'b1;
    end
  end

endmodule

// File: doc/fu_agu_sb.md
FU_AGU_SB -- requirements
Module: fu_agu_sb

Interface
REQ-001 SHALL have parameter SB_DEPTH, default 4: store-buffer entries; power of two, at least 2.
REQ-002 SHALL have parameter TAG_W, default 6: width of the destination tag.
REQ-003 SHALL have port clk, input, 1: the single clock; all state updates on rising edge.
REQ-004 SHALL have port reset, input, 1: asynchronous, active-high reset.
REQ-005 SHALL have port in_valid, input, 1: issue request present.
REQ-006 SHALL have port in_ready, output, 1: request accepted this cycle when in_valid=1 and in_ready=1.
REQ-007 SHALL have port op, input, 8: one-hot {lb,lbu,lh,lhu,lw,sb,sh,sw}, lw/sw in bits [3]/[0].
REQ-008 SHALL have ports base, offset, st_data, each input, 32: address base, sign-extended offset, store data.
REQ-009 SHALL have port tag, input, TAG_W: destination tag returned with the load or exception result.
REQ-010 SHALL have ports res_valid (1), res_tag (TAG_W), res_data (32), res_exc (1), res_badvaddr (32), all outputs: result pulse.
REQ-011 SHALL have ports mem_req (1), mem_we (1), mem_wen (4), mem_addr (32), mem_wdata (32), all outputs: memory request.
REQ-012 SHALL have ports mem_gnt (1), mem_rvalid (1), mem_rdata (32), all inputs: request grant, and load data arriving at least 1 cycle after grant.
REQ-013 SHALL have port sb_empty, output, 1: store buffer holds no entries.

Function
REQ-014 SHALL compute vaddr = base + offset, modulo 2^32, combinationally at acceptance.
REQ-015 SHALL derive the byte mask as follows.
- byte ops: decoder of vaddr[1:0].
- half ops: 4'b0011 for vaddr[1]=0, 4'b1100 for vaddr[1]=1.
- word ops: 4'b1111.
REQ-016 SHALL flag misalignment for half ops with vaddr[0]=1 and for word ops with vaddr[1:0]!=0.
REQ-017 SHALL not access memory or the buffer for a misaligned op, and SHALL pulse the following on the next cycle.
- res_valid=1, res_exc=1, res_badvaddr=vaddr, res_tag=tag, res_data=0.
- This applies to stores as well.
REQ-018 SHALL drive in_ready=1 only when the FSM is IDLE and the buffer is not full; otherwise in_ready=0, regardless of op.
REQ-019 SHALL push an accepted aligned store into the buffer tail as {word address, mask, lane-replicated data}.
- Lane replication: sb -> 4 copies of [7:0]; sh -> 2 copies of [15:0]; sw -> data unchanged.
- A store produces no res_valid.
REQ-020 SHALL keep buffer entries in FIFO order, with head/tail pointers wrapping modulo SB_DEPTH and a count from 0 to SB_DEPTH.
REQ-021 SHALL drain the head entry when the FSM is not in REQ or WAIT and the buffer is not empty.
- Drive mem_req=1, mem_we=1, mem_wen=mask, mem_addr={addr,2'b00}, mem_wdata=data.
- Pop the head on the mem_gnt cycle.
REQ-022 SHALL classify an accepted aligned load against the buffer contents plus any entry popped the same cycle.
- An entry overlaps when its word address is equal and mask AND load-mask is nonzero.
- No overlap -> go to REQ.
- Youngest overlapping entry's mask covers the whole load mask -> forward: next-cycle result built from that entry's data, FSM stays IDLE.
- Otherwise -> go to HAZ.
REQ-023 SHALL implement FSM states IDLE, HAZ, REQ, WAIT with these transitions.
- HAZ: drain continues; go to REQ when no overlapping entry remains, re-evaluated each cycle.
- REQ: mem_req=1, mem_we=0, mem_wen=0, mem_addr=vaddr aligned down to a word; go to WAIT on mem_gnt.
- WAIT: on mem_rvalid, pulse the result and go to IDLE.
REQ-024 SHALL give the load request in REQ priority over the drain; no drain is issued in REQ or WAIT.
REQ-025 SHALL hold the load vaddr, mask, op and tag in registers from acceptance until the result pulse.
REQ-026 SHALL format res_data from the selected lane.
- lb/lh sign-extend; lbu/lhu zero-extend; lw takes the full word.
- res_exc=0 and res_badvaddr=0 on a non-exception result.
REQ-027 SHALL assert res_valid for exactly one cycle per accepted load or misaligned op.
REQ-028 SHALL produce a forwarded-load result 1 cycle after acceptance, and a memory-load result the cycle after mem_rvalid.
REQ-029 SHALL ignore mem_rvalid outside WAIT.
REQ-030 SHALL hold a push and a pop in the same cycle at a constant count; a push into a full buffer cannot occur because in_ready=0.

Reset
REQ-031 SHALL, while reset=1 and independent of clk, hold the following.
- FSM=IDLE; buffer count, head and tail =0; entries discarded.
- All res_* =0; mem_req=0, mem_we=0, mem_wen=0, mem_addr=0, mem_wdata=0.
- sb_empty=1; in_ready=0.
REQ-032 SHALL discard any in-flight load or buffered store on reset mid-operation, and SHALL ignore a later mem_rvalid for that load.

Verification
REQ-033 SHALL be checked by these directed scenarios.
- sw base=0x100 offset=4 data=0xAABBCCDD, mem_gnt=1 -> one write, addr 0x104, wen 4'b1111, then sb_empty=1.
- sb 0x55 to 0x203 with grant held low, then lbu 0x203 -> forward, res_data=0x00000055 one cycle after accept, no mem read.
- sh 0x8001 to 0x300 held, then lw 0x300 -> HAZ until the store is granted, then read; mem_rdata=0x12348001 -> res_data=0x12348001.
- lh vaddr=0x401 -> res_exc=1, res_badvaddr=0x401, no mem_req; sw to 0x402 -> exception, sb_empty stays 1.
- Fill SB_DEPTH stores with no grant -> in_ready=0; one grant -> in_ready=1 next cycle; a head index wrap is exercised.
- Reset asserted in WAIT -> all outputs 0 immediately; mem_rvalid after release -> no res_valid.
